// File: rtl/jtopl_wrseq.sv
// Host-side write sequencer for the OPL register port: queues (register, value)
// requests and emits address/data writes separated by cen-counted busy waits.
module jtopl_wrseq #(
  parameter int unsigned FIFO_AW   = 2,
  parameter int unsigned ADDR_WAIT = 12,
  parameter int unsigned DATA_WAIT = 84,
  parameter bit          SKIP_SAME = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_val,
  output logic       busy,
  output logic       opl_write,
  output logic       opl_addr,
  output logic [7:0] opl_din
);

  localparam int unsigned Depth = 1 << FIFO_AW;

  typedef enum logic [2:0] {StIdle, StAddr, StAwait, StData, StDwait} state_e;

  logic [15:0]        mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, push, pop;
  logic [7:0]         head_reg, head_val;

  state_e     state;
  logic [7:0] cnt;
  logic [7:0] cur_reg, cur_val, last_reg;
  logic       last_valid;
  logic       skip;

  // count only reaches Depth when every slot is occupied
  assign full      = count[FIFO_AW];
  assign empty     = (count == '0);
  assign req_ready = ~full;
  assign push      = req_valid & ~full;
  assign pop       = (state == StIdle) & ~empty;
  assign head_reg  = mem[rd_ptr][15:8];
  assign head_val  = mem[rd_ptr][7:0];
  assign busy      = ~empty | (state != StIdle);
  assign skip      = SKIP_SAME && last_valid && (head_reg == last_reg);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_reg, req_val};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Strobes are set on the edge entering StAddr/StData, so the wait count
  // is loaded on the following edge and cen in the strobe cycle is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= '0;
      cur_reg    <= '0;
      cur_val    <= '0;
      last_reg   <= '0;
      last_valid <= 1'b0;
      opl_write  <= 1'b0;
      opl_addr   <= 1'b0;
      opl_din    <= '0;
    end else begin
      opl_write <= 1'b0;
      case (state)
        StIdle: begin
          if (!empty) begin
            cur_reg   <= head_reg;
            cur_val   <= head_val;
            opl_write <= 1'b1;
            if (skip) begin
              state    <= StData;
              opl_addr <= 1'b1;
              opl_din  <= head_val;
            end else begin
              state    <= StAddr;
              opl_addr <= 1'b0;
              opl_din  <= head_reg;
            end
          end
        end
        StAddr: begin
          last_reg   <= cur_reg;
          last_valid <= 1'b1;
          cnt        <= 8'(ADDR_WAIT);
          state      <= StAwait;
        end
        StAwait: begin
          if (cnt == '0) begin
            state     <= StData;
            opl_write <= 1'b1;
            opl_addr  <= 1'b1;
            opl_din   <= cur_val;
          end else if (cen) begin
            cnt <= cnt - 8'd1;
          end
        end
        StData: begin
          cnt   <= 8'(DATA_WAIT);
          state <= StDwait;
        end
        StDwait: begin
          if (cnt == '0) state <= StIdle;
          else if (cen)  cnt   <= cnt - 8'd1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jtopl_wrseq.sv
// Directed bench for jtopl_wrseq: latency, wait spacing, address skipping,
// FIFO full/wrap, cen division and reset abort.
module tb_jtopl_wrseq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       req_valid = 1'b0, req_valid2 = 1'b0;
  logic [7:0] req_reg = '0, req_val = '0;
  logic       req_ready, busy, opl_write, opl_addr;
  logic [7:0] opl_din;
  logic       req_ready2, busy2, opl_write2, opl_addr2;
  logic [7:0] opl_din2;

  int  checks = 0, failures = 0;
  int  e = 0;
  int  base = 0;
  bit  div4 = 1'b0;

  always #5 clk = ~clk;

  jtopl_wrseq u_dut (
    .clk(clk), .rst(rst), .cen(cen), .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_val(req_val), .busy(busy), .opl_write(opl_write),
    .opl_addr(opl_addr), .opl_din(opl_din)
  );

  // No address skipping and zero address wait
  jtopl_wrseq #(.SKIP_SAME(1'b0), .ADDR_WAIT(0), .DATA_WAIT(3)) u_ns (
    .clk(clk), .rst(rst), .cen(cen), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_reg(req_reg), .req_val(req_val), .busy(busy2), .opl_write(opl_write2),
    .opl_addr(opl_addr2), .opl_din(opl_din2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it. e = edge index.
  task automatic step();
    @(posedge clk);
    #1;
    e++;
    if (div4) cen = (((e + 1 - base) % 4) == 0);
  endtask

  task automatic push(input bit sel, input logic [7:0] r, input logic [7:0] v);
    req_reg = r;
    req_val = v;
    if (sel) req_valid2 = 1'b1;
    else     req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
    req_valid2 = 1'b0;
  endtask

  task automatic wait_write(input bit sel, input int lim, output int at, output int a,
                            output int d);
    bit got = 1'b0;
    at = -1; a = -1; d = -1;
    for (int i = 0; i < lim && !got; i++) begin
      step();
      if (sel ? opl_write2 : opl_write) begin
        got = 1'b1;
        at  = e;
        a   = int'(sel ? opl_addr2 : opl_addr);
        d   = int'(sel ? opl_din2 : opl_din);
      end
    end
    chk("strobe_timeout", int'(got), 1);
  endtask

  task automatic wait_idle(input bit sel, input int lim, output int at, output int nstb);
    bit done = 1'b0;
    at = -1; nstb = 0;
    for (int i = 0; i < lim && !done; i++) begin
      step();
      if (sel ? opl_write2 : opl_write) nstb++;
      if (!(sel ? busy2 : busy)) begin
        done = 1'b1;
        at   = e;
      end
    end
    chk("idle_timeout", int'(done), 1);
  endtask

  int at, a, d, s, dd, n;
  logic [8:0] seq3 [9] = '{9'h101, 9'h011, 9'h1a1, 9'h012, 9'h1a2,
                           9'h013, 9'h1a3, 9'h014, 9'h1a4};

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_write", int'(opl_write), 0);
    chk("rst_addr", int'(opl_addr), 0);
    chk("rst_din", int'(opl_din), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    step();

    // 1: single request, cen always high
    push(1'b0, 8'ha0, 8'h55);
    chk("t1_no_strobe_yet", int'(opl_write), 0);
    chk("t1_busy", int'(busy), 1);
    step();
    s = e;
    chk("t1_addr_strobe", int'(opl_write), 1);
    chk("t1_addr_phase", int'(opl_addr), 0);
    chk("t1_addr_din", int'(opl_din), 8'ha0);
    step();
    chk("t1_strobe_1clk", int'(opl_write), 0);
    chk("t1_bus_held", int'(opl_din), 8'ha0);
    wait_write(1'b0, 200, at, a, d);
    chk("t1_data_spacing", at - s, 14);       // 12 ticks + strobe cycle + zero check
    chk("t1_data_phase", a, 1);
    chk("t1_data_din", d, 8'h55);
    dd = at;
    wait_idle(1'b0, 200, at, n);
    chk("t1_idle_spacing", at - dd, 86);      // 84 ticks + strobe cycle + zero check
    chk("t1_no_extra_strobe", n, 0);
    chk("t1_bus_held_idle", int'(opl_din), 8'h55);

    // 2: same register twice, SKIP_SAME=1
    push(1'b0, 8'hb0, 8'h20);
    push(1'b0, 8'hb0, 8'h31);
    chk("t2_addr_strobe", int'(opl_write), 1);
    chk("t2_addr_din", int'(opl_din), 8'hb0);
    wait_write(1'b0, 200, at, a, d);
    chk("t2_data1", (a << 8) | d, 9'h120);
    wait_write(1'b0, 200, at, a, d);
    chk("t2_skip_data2", (a << 8) | d, 9'h131);
    wait_idle(1'b0, 200, at, n);
    chk("t2_no_extra_strobe", n, 0);

    // 2b: same register twice, SKIP_SAME=0, ADDR_WAIT=0
    push(1'b1, 8'hb0, 8'h20);
    push(1'b1, 8'hb0, 8'h31);
    s = e;
    chk("t2n_addr1", ({31'd0, opl_write2} << 9) | (int'(opl_addr2) << 8) | opl_din2, 10'h2b0);
    wait_write(1'b1, 50, at, a, d);
    chk("t2n_data1", (a << 8) | d, 9'h120);
    chk("t2n_zero_wait_spacing", at - s, 2);
    dd = at;
    wait_write(1'b1, 50, at, a, d);
    chk("t2n_addr_repeat", (a << 8) | d, 9'h0b0);
    chk("t2n_dwait_spacing", at - dd, 6);
    wait_write(1'b1, 50, at, a, d);
    chk("t2n_data2", (a << 8) | d, 9'h131);
    wait_idle(1'b1, 50, at, n);
    chk("t2n_ready", int'(req_ready2), 1);

    // 3: stall in AWAIT with cen low, overfill the FIFO
    cen = 1'b0;
    push(1'b0, 8'hc0, 8'h01);
    step();
    chk("t3_addr_c0", int'(opl_din), 8'hc0);
    for (int i = 1; i <= 5; i++) begin
      push(1'b0, 8'(8'h10 + i), 8'(8'ha0 + i));
      if (i == 3) chk("t3_ready_after3", int'(req_ready), 1);
      if (i == 4) chk("t3_ready_after4", int'(req_ready), 0);
      if (i == 5) chk("t3_ready_after5", int'(req_ready), 0);
    end
    step();
    chk("t3_stalled", int'(busy), 1);
    cen = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_write(1'b0, 200, at, a, d);
      chk($sformatf("t3_order%0d", i), (a << 8) | d, int'(seq3[i]));
    end
    wait_idle(1'b0, 200, at, n);
    chk("t3_fifth_dropped", n, 0);
    chk("t3_ready_again", int'(req_ready), 1);
    // Refill across the pointer wrap; 0x14 is the last register selected
    push(1'b0, 8'h14, 8'hb0);
    push(1'b0, 8'h20, 8'hb1);
    chk("t3_wrap_skip", (int'(opl_write) << 9) | (int'(opl_addr) << 8) | opl_din, 10'h3b0);
    wait_write(1'b0, 200, at, a, d);
    chk("t3_wrap_addr", (a << 8) | d, 9'h020);
    wait_write(1'b0, 200, at, a, d);
    chk("t3_wrap_data", (a << 8) | d, 9'h1b1);
    wait_idle(1'b0, 200, at, n);

    // 4: cen one-in-four, phase aligned to the push edge
    div4 = 1'b1;
    base = e + 1;
    cen  = 1'b1;
    push(1'b0, 8'h30, 8'hc0);
    push(1'b0, 8'h31, 8'hc1);
    s = e;
    chk("t4_addr", (int'(opl_write) << 9) | (int'(opl_addr) << 8) | opl_din, 10'h230);
    wait_write(1'b0, 1000, at, a, d);
    chk("t4_addr_data_spacing", at - s, 48);
    chk("t4_data", (a << 8) | d, 9'h1c0);
    dd = at;
    wait_write(1'b0, 1000, at, a, d);
    chk("t4_data_next_spacing", at - dd, 337);  // 84 ticks x 4 clk + IDLE pop cycle
    chk("t4_next_addr", (a << 8) | d, 9'h031);
    div4 = 1'b0;
    cen  = 1'b1;
    wait_idle(1'b0, 1000, at, n);

    // 5: reset during AWAIT with a second request queued
    push(1'b0, 8'h40, 8'hd0);
    step();
    chk("t5_addr", int'(opl_din), 8'h40);
    push(1'b0, 8'h41, 8'hd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_write", int'(opl_write), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_din", int'(opl_din), 0);
    chk("t5_rst_ready", int'(req_ready), 1);
    n = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (opl_write || busy) n++;
    end
    chk("t5_aborted", n, 0);
    push(1'b0, 8'h40, 8'hd2);
    step();
    chk("t5_addr_after_rst", (int'(opl_write) << 9) | (int'(opl_addr) << 8) | opl_din, 10'h240);
    wait_write(1'b0, 200, at, a, d);
    chk("t5_data_after_rst", (a << 8) | d, 9'h1d2);
    wait_idle(1'b0, 200, at, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
